// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Gshare branch-direction predictor for the LC-3b fetch stage. The fetch PC
//   is XOR-hashed with a non-speculative global history register (GHR) to
//   index a table of 2-bit saturating counters (PHT). Counters are trained
//   when a conditional branch resolves. After reset, a sweep writes CTR_INIT
//   into every PHT entry before any prediction or training is allowed.
//
// Ports
//   i_clk                  clock; all state updates on posedge
//   i_reset                synchronous, active-high reset
//   i_fetch_pc             PC being fetched this cycle
//   o_branch_prediction    predicted taken (counter MSB), zero-latency; feeds BTB
//   o_pred_ghr             GHR value used for this lookup, carried down the pipe
//   o_init_busy            high while the PHT init sweep runs
//   i_resolve_valid        a conditional branch resolved this cycle
//   i_resolve_pc           PC of the resolved branch
//   i_resolve_ghr          o_pred_ghr value carried with that branch
//   i_resolve_taken        actual branch direction
//   i_resolve_mispredict   predicted direction differed from actual
//   o_mispredict_count     saturating count of resolved mispredicts
module gshare_predictor #(
  parameter int         INDEX_BITS = 7,
  parameter logic [1:0] CTR_INIT   = 2'b01,
  parameter int         MISS_CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [15:0]           i_fetch_pc,
  output logic                  o_branch_prediction,
  output logic [INDEX_BITS-1:0] o_pred_ghr,
  output logic                  o_init_busy,
  input  logic                  i_resolve_valid,
  input  logic [15:0]           i_resolve_pc,
  input  logic [INDEX_BITS-1:0] i_resolve_ghr,
  input  logic                  i_resolve_taken,
  input  logic                  i_resolve_mispredict,
  output logic [MISS_CNT_W-1:0] o_mispredict_count
);

  localparam int                    PHT_ENTRIES = 1 << INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] PTR_LAST    = {INDEX_BITS{1'b1}};
  localparam logic [INDEX_BITS-1:0] PTR_ONE     = {{(INDEX_BITS-1){1'b0}}, 1'b1};
  localparam logic [MISS_CNT_W-1:0] CNT_MAX     = {MISS_CNT_W{1'b1}};
  localparam logic [MISS_CNT_W-1:0] CNT_ONE     = {{(MISS_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [INDEX_BITS-1:0]   r_ptr;
  logic [INDEX_BITS-1:0]   r_ghr;
  logic [MISS_CNT_W-1:0]   r_miss_cnt;
  logic [1:0]              r_pht [PHT_ENTRIES];

  logic [INDEX_BITS-1:0]   w_idx;
  logic [INDEX_BITS-1:0]   w_uidx;
  logic                    w_resolve_en;
  logic                    w_pht_we;
  logic [INDEX_BITS-1:0]   w_pht_waddr;
  logic [1:0]              w_pht_wdata;
  logic                    w_unused_pc_bits;

  // Saturating 2-bit counter step: up on taken, down on not-taken, no wrap.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

  // PCs are word-aligned, so bit 0 never contributes to the hash.
  assign w_idx  = i_fetch_pc[INDEX_BITS:1] ^ r_ghr;
  assign w_uidx = i_resolve_pc[INDEX_BITS:1] ^ i_resolve_ghr;

  assign w_unused_pc_bits = ^{i_fetch_pc[15:INDEX_BITS+1], i_fetch_pc[0],
                              i_resolve_pc[15:INDEX_BITS+1], i_resolve_pc[0]};

  // Training is only honoured once the sweep has finished.
  assign w_resolve_en = (r_state == ST_READY) && i_resolve_valid;

  // Next-state logic for the init sweep FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_ptr == PTR_LAST) begin
          w_state_next = ST_READY;
        end else begin
          w_state_next = ST_INIT;
        end
      end
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_INIT;
    endcase
  end

  // Single PHT write port: the sweep owns it during INIT, training afterwards.
  always_comb begin
    w_pht_we    = 1'b0;
    w_pht_waddr = {INDEX_BITS{1'b0}};
    w_pht_wdata = 2'b00;
    if (i_reset) begin
      w_pht_we = 1'b0;
    end else if (r_state == ST_INIT) begin
      w_pht_we    = 1'b1;
      w_pht_waddr = r_ptr;
      w_pht_wdata = CTR_INIT;
    end else if (w_resolve_en) begin
      w_pht_we    = 1'b1;
      w_pht_waddr = w_uidx;
      w_pht_wdata = ctr_update(r_pht[w_uidx], i_resolve_taken);
    end else begin
      w_pht_we = 1'b0;
    end
  end

  // Control state: FSM, sweep pointer, GHR and mispredict counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_INIT;
      r_ptr      <= {INDEX_BITS{1'b0}};
      r_ghr      <= {INDEX_BITS{1'b0}};
      r_miss_cnt <= {MISS_CNT_W{1'b0}};
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_INIT) begin
        r_ptr <= r_ptr + PTR_ONE;
      end
      if (w_resolve_en) begin
        r_ghr <= {r_ghr[INDEX_BITS-2:0], i_resolve_taken};
        if (i_resolve_mispredict && (r_miss_cnt != CNT_MAX)) begin
          r_miss_cnt <= r_miss_cnt + CNT_ONE;
        end
      end
    end
  end

  // PHT storage; contents are defined by the sweep, not by reset.
  always_ff @(posedge i_clk) begin
    if (w_pht_we) begin
      r_pht[w_pht_waddr] <= w_pht_wdata;
    end
  end

  // Lookup reads the pre-update counter, so a same-cycle write shows next cycle.
  assign o_branch_prediction = (r_state == ST_READY) ? r_pht[w_idx][1] : 1'b0;
  assign o_pred_ghr          = r_ghr;
  assign o_init_busy         = (r_state == ST_INIT);
  assign o_mispredict_count  = r_miss_cnt;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor
//   Directed testbench for gshare_predictor (INDEX_BITS=7, MISS_CNT_W=4).
module tb_gshare_predictor;

  logic        clk;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        branch_prediction;
  logic [6:0]  pred_ghr;
  logic        init_busy;
  logic        resolve_valid;
  logic [15:0] resolve_pc;
  logic [6:0]  resolve_ghr;
  logic        resolve_taken;
  logic        resolve_mispredict;
  logic [3:0]  mispredict_count;

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] m_ghr;

  gshare_predictor #(
    .INDEX_BITS (7),
    .CTR_INIT   (2'b01),
    .MISS_CNT_W (4)
  ) dut (
    .i_clk                (clk),
    .i_reset              (reset),
    .i_fetch_pc           (fetch_pc),
    .o_branch_prediction  (branch_prediction),
    .o_pred_ghr           (pred_ghr),
    .o_init_busy          (init_busy),
    .i_resolve_valid      (resolve_valid),
    .i_resolve_pc         (resolve_pc),
    .i_resolve_ghr        (resolve_ghr),
    .i_resolve_taken      (resolve_taken),
    .i_resolve_mispredict (resolve_mispredict),
    .o_mispredict_count   (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One resolve cycle; m_ghr tracks the expected GHR shift.
  task automatic do_resolve(input logic [15:0] pc, input logic [6:0] ghr,
                            input logic taken, input logic misp);
    resolve_valid      = 1'b1;
    resolve_pc         = pc;
    resolve_ghr        = ghr;
    resolve_taken      = taken;
    resolve_mispredict = misp;
    tick();
    resolve_valid      = 1'b0;
    m_ghr = {m_ghr[5:0], taken};
  endtask

  // Fetch PC whose lookup index is idx under the bench's current GHR.
  function automatic logic [15:0] pc_for_idx(input logic [6:0] idx);
    logic [6:0] h;
    h = idx ^ m_ghr;
    return {8'h00, h, 1'b0};
  endfunction

  // T1 + T5: reset, 128-cycle sweep, resolve pulse at INIT cycle 40 ignored.
  task automatic test_reset();
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ghr = 7'd0;
    n_vec++; if (init_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", init_busy); end
    n_vec++; if (branch_prediction !== 1'b0) begin n_err++; $display("FAIL reset_pred got=%b exp=0", branch_prediction); end
    n_vec++; if (pred_ghr !== 7'd0) begin n_err++; $display("FAIL reset_ghr got=%h exp=0", pred_ghr); end
    n_vec++; if (mispredict_count !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", mispredict_count); end
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      n_vec++; if (branch_prediction !== 1'b0) begin n_err++; $display("FAIL init_pred cyc=%0d got=%b exp=0", n, branch_prediction); end
      resolve_valid      = (n == 40);
      resolve_pc         = 16'h0000;
      resolve_ghr        = 7'd0;
      resolve_taken      = 1'b1;
      resolve_mispredict = 1'b1;
      tick();
      n++;
    end
    resolve_valid = 1'b0;
    n_vec++; if (n !== 128) begin n_err++; $display("FAIL init_len got=%0d exp=128", n); end
    n_vec++; if (pred_ghr !== 7'd0) begin n_err++; $display("FAIL init_ghr got=%h exp=0", pred_ghr); end
    n_vec++; if (mispredict_count !== 4'd0) begin n_err++; $display("FAIL init_cnt got=%0d exp=0", mispredict_count); end
    for (int i = 0; i < 128; i++) begin
      fetch_pc = {8'h00, i[6:0], 1'b0};
      #1;
      n_vec++; if (branch_prediction !== 1'b0) begin n_err++; $display("FAIL pht_init idx=%0d got=%b exp=0", i, branch_prediction); end
    end
  endtask

  // T2: two taken resolves on index 0 make PHT[0]=11 and GHR=0000011.
  task automatic test_train();
    do_resolve(16'h3000, 7'd0, 1'b1, 1'b1);
    do_resolve(16'h3000, 7'd0, 1'b1, 1'b0);
    fetch_pc = 16'h0006;
    #1;
    n_vec++; if (pred_ghr !== 7'b0000011) begin n_err++; $display("FAIL train_ghr got=%b exp=0000011", pred_ghr); end
    n_vec++; if (branch_prediction !== 1'b1) begin n_err++; $display("FAIL train_pred got=%b exp=1", branch_prediction); end
    n_vec++; if (mispredict_count !== 4'd1) begin n_err++; $display("FAIL train_cnt got=%0d exp=1", mispredict_count); end
  endtask

  // T3: saturation at 11 and 00 on index 5.
  task automatic test_saturation();
    for (int i = 0; i < 5; i++) do_resolve(16'h000A, 7'd0, 1'b1, 1'b0);
    fetch_pc = pc_for_idx(7'd5); #1;
    n_vec++; if (branch_prediction !== 1'b1) begin n_err++; $display("FAIL sat_hi got=%b exp=1", branch_prediction); end
    do_resolve(16'h000A, 7'd0, 1'b0, 1'b0);
    fetch_pc = pc_for_idx(7'd5); #1;
    n_vec++; if (branch_prediction !== 1'b1) begin n_err++; $display("FAIL sat_10 got=%b exp=1", branch_prediction); end
    do_resolve(16'h000A, 7'd0, 1'b0, 1'b0);
    do_resolve(16'h000A, 7'd0, 1'b0, 1'b0);
    fetch_pc = pc_for_idx(7'd5); #1;
    n_vec++; if (branch_prediction !== 1'b0) begin n_err++; $display("FAIL sat_00 got=%b exp=0", branch_prediction); end
    do_resolve(16'h000A, 7'd0, 1'b0, 1'b0);
    fetch_pc = pc_for_idx(7'd5); #1;
    n_vec++; if (branch_prediction !== 1'b0) begin n_err++; $display("FAIL sat_lo got=%b exp=0", branch_prediction); end
    do_resolve(16'h000A, 7'd0, 1'b1, 1'b0);
    fetch_pc = pc_for_idx(7'd5); #1;
    n_vec++; if (branch_prediction !== 1'b0) begin n_err++; $display("FAIL sat_01 got=%b exp=0", branch_prediction); end
    n_vec++; if (pred_ghr !== m_ghr) begin n_err++; $display("FAIL sat_ghr got=%b exp=%b", pred_ghr, m_ghr); end
  endtask

  // T4: lookup and taken-resolve on index 9 in the same cycle.
  task automatic test_back_to_back();
    fetch_pc           = pc_for_idx(7'd9);
    resolve_valid      = 1'b1;
    resolve_pc         = 16'h0012;
    resolve_ghr        = 7'd0;
    resolve_taken      = 1'b1;
    resolve_mispredict = 1'b0;
    #2;
    n_vec++; if (branch_prediction !== 1'b0) begin n_err++; $display("FAIL coll_now got=%b exp=0", branch_prediction); end
    n_vec++; if (pred_ghr !== m_ghr) begin n_err++; $display("FAIL coll_ghr got=%b exp=%b", pred_ghr, m_ghr); end
    tick();
    resolve_valid = 1'b0;
    m_ghr = {m_ghr[5:0], 1'b1};
    fetch_pc = pc_for_idx(7'd9);
    #1;
    n_vec++; if (branch_prediction !== 1'b1) begin n_err++; $display("FAIL coll_next got=%b exp=1", branch_prediction); end
  endtask

  // T6: reset at INIT cycle 60 restarts a full sweep; count saturates at 15.
  task automatic test_midinit_reset();
    int n;
    reset = 1'b1; tick(); reset = 1'b0;
    m_ghr = 7'd0;
    for (int i = 0; i < 60; i++) tick();
    n_vec++; if (init_busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got=%b exp=1", init_busy); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_vec++; if (mispredict_count !== 4'd0) begin n_err++; $display("FAIL mid_cnt got=%0d exp=0", mispredict_count); end
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_vec++; if (n !== 128) begin n_err++; $display("FAIL mid_len got=%0d exp=128", n); end
    n_vec++; if (pred_ghr !== 7'd0) begin n_err++; $display("FAIL mid_ghr got=%b exp=0", pred_ghr); end
    for (int i = 0; i < 14; i++) do_resolve(16'h0100 + 16'(i * 2), 7'd0, 1'b0, 1'b1);
    n_vec++; if (mispredict_count !== 4'd14) begin n_err++; $display("FAIL cnt_14 got=%0d exp=14", mispredict_count); end
    for (int i = 0; i < 6; i++) do_resolve(16'h0200 + 16'(i * 2), 7'd0, 1'b0, 1'b1);
    n_vec++; if (mispredict_count !== 4'd15) begin n_err++; $display("FAIL cnt_sat got=%0d exp=15", mispredict_count); end
  endtask

  initial begin
    reset              = 1'b0;
    fetch_pc           = 16'h0000;
    resolve_valid      = 1'b0;
    resolve_pc         = 16'h0000;
    resolve_ghr        = 7'd0;
    resolve_taken      = 1'b0;
    resolve_mispredict = 1'b0;
    m_ghr              = 7'd0;
    #2;
    test_reset();
    test_train();
    test_saturation();
    test_back_to_back();
    test_midinit_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
